// File: rtl/mmio_mem.sv
// ---------------------------------------------------------------------------
// mmio_mem
//   Memory-mapped data RAM plus a small set of peripheral registers for a
//   simple 32-bit processor: an LED register, a free-running cycle counter
//   and a byte-wide transmit FIFO with status/overflow reporting.
//
// Address map (byte addresses, adr[1:0] ignored):
//   0x00000000 .. MEMWORDS*4-1 : RAM, asynchronous read, synchronous write
//   0xFFFF0000                  : LED     r/w  {24'b0, led}
//   0xFFFF0004                  : CYCLE   r/w  any write clears the counter
//   0xFFFF0008                  : TXDATA  r/w  write pushes, read peeks head
//   0xFFFF000C                  : STATUS  r/w  {count[4:0], ovf, empty, full}
//                                              write bit2=1 clears ovf
//   anything else               : reads 0, writes ignored
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   adr        processor byte address
//   writedata  processor store data
//   memwrite   store strobe, sampled on each rising clk
//   readdata   load/fetch data, combinational from adr
//   led        LED register value
//   tx_data    FIFO head byte (don't-care while tx_valid=0)
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts the head byte this cycle
// ---------------------------------------------------------------------------
module mmio_mem #(
    parameter int MEMWORDS  = 64,
    parameter int FIFODEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(MEMWORDS);
    localparam int PW = $clog2(FIFODEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] RAM_BYTES   = 32'(MEMWORDS * 4);
    localparam logic [31:0] ADDR_LED    = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_000C;

    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFODEPTH);

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic          sel_ram;
    logic          sel_led;
    logic          sel_cycle;
    logic          sel_txdata;
    logic          sel_status;
    logic [AW-1:0] mem_idx;

    // RAM_BYTES is a multiple of 4, so the compare is unaffected by adr[1:0].
    assign sel_ram    = (adr < RAM_BYTES);
    assign sel_led    = (adr[31:2] == ADDR_LED[31:2]);
    assign sel_cycle  = (adr[31:2] == ADDR_CYCLE[31:2]);
    assign sel_txdata = (adr[31:2] == ADDR_TXDATA[31:2]);
    assign sel_status = (adr[31:2] == ADDR_STATUS[31:2]);
    assign mem_idx    = adr[AW+1:2];

    logic wr_led;
    logic wr_cycle;
    logic wr_txdata;
    logic wr_status;

    assign wr_led    = memwrite & sel_led;
    assign wr_cycle  = memwrite & sel_cycle;
    assign wr_txdata = memwrite & sel_txdata;
    assign wr_status = memwrite & sel_status;

    // -----------------------------------------------------------------------
    // RAM: no reset, contents survive a reset pulse
    // -----------------------------------------------------------------------
    logic [31:0] mem [MEMWORDS];

    always_ff @(posedge clk) begin
        if (memwrite && sel_ram) begin
            mem[mem_idx] <= writedata;
        end
    end

    // -----------------------------------------------------------------------
    // TX FIFO control
    // -----------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFODEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic ovf_set;
    logic ovf_clr;

    assign fifo_full  = (count == FIFO_FULL);
    assign fifo_empty = (count == '0);
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr];

    // A pop frees the head slot at the same edge, so a push into a full FIFO
    // is accepted when the consumer drains one byte in that cycle.
    assign pop     = tx_valid & tx_ready;
    assign push    = wr_txdata & (~fifo_full | pop);
    assign ovf_set = wr_txdata & fifo_full & ~pop;
    assign ovf_clr = wr_status & writedata[2];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= writedata[7:0];
        end
    end

    // -----------------------------------------------------------------------
    // Registers with reset
    // -----------------------------------------------------------------------
    logic [31:0] cycle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led    <= '0;
            cycle  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_led) begin
                led <= writedata[7:0];
            end

            // Clearing wins over counting; the add wraps naturally at 2^32.
            if (wr_cycle) begin
                cycle <= '0;
            end else begin
                cycle <= cycle + 32'd1;
            end

            // Depth is a power of two, so the pointers wrap on overflow.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    logic [31:0] status;

    assign status = {24'b0, 5'(count), ovf, fifo_empty, fifo_full};

    always_comb begin
        readdata = 32'h0000_0000;
        if (sel_ram) begin
            readdata = mem[mem_idx];
        end else if (sel_led) begin
            readdata = {24'b0, led};
        end else if (sel_cycle) begin
            readdata = cycle;
        end else if (sel_txdata) begin
            // Peek only; the head byte is meaningless while empty.
            readdata = fifo_empty ? 32'h0000_0000 : {24'b0, tx_data};
        end else if (sel_status) begin
            readdata = status;
        end
    end

endmodule

// File: tb/tb_mmio_mem.sv
`timescale 1ns/1ps
module tb_mmio_mem;

    localparam logic [31:0] A_LED = 32'hFFFF_0000;
    localparam logic [31:0] A_CYC = 32'hFFFF_0004;
    localparam logic [31:0] A_TX  = 32'hFFFF_0008;
    localparam logic [31:0] A_ST  = 32'hFFFF_000C;
    localparam logic [31:0] A_UNM = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    mmio_mem #(.MEMWORDS(64), .FIFODEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .led       (led),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #50 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];

    task automatic compare_exp(input string tag, input logic [31:0] obs, input logic [31:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic expect_val(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            compare_exp(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic compare_tx(input string tag);
        if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<no byte queued>", tag, tx_data);
        end else begin
            compare_exp(tag, {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
        expect_val(e);
        adr      = a;
        memwrite = 1'b0;
        #1;
        compare(tag, readdata);
    endtask

    task automatic sig_chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(e);
        compare(tag, obs);
    endtask

    // Called in the low clock phase; the store lands on the following rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        adr       = '0;
        writedata = '0;
        memwrite  = 1'b0;
        tx_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        #1;
        sig_chk("rst_led", {24'b0, led}, 32'h0);
        sig_chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        rd_chk("rst_status", A_ST, 32'h0000_0002);
        rd_chk("rst_cycle", A_CYC, 32'h0);

        // cycle counter
        repeat (10) @(negedge clk);
        rd_chk("cycle_10", A_CYC, 32'd10);
        do_write(A_CYC, 32'hDEAD_BEEF);
        rd_chk("cycle_clr", A_CYC, 32'd0);
        @(negedge clk);
        rd_chk("cycle_after_clr", A_CYC, 32'd1);

        // RAM
        do_write(32'h0000_003C, 32'h1234_5678);
        rd_chk("ram_3c", 32'h0000_003C, 32'h1234_5678);
        rd_chk("ram_3e", 32'h0000_003E, 32'h1234_5678);
        rd_chk("ram_oob", 32'h0000_0100, 32'h0);
        do_write(32'h0000_00FC, 32'hCAFE_F00D);
        rd_chk("ram_top", 32'h0000_00FC, 32'hCAFE_F00D);
        rd_chk("ram_3c_kept", 32'h0000_003C, 32'h1234_5678);

        // LED and unmapped space
        do_write(A_LED, 32'h0000_01A5);
        sig_chk("led_port", {24'b0, led}, 32'h0000_00A5);
        rd_chk("led_read", A_LED, 32'h0000_00A5);
        do_write(A_UNM, 32'hFFFF_FFFF);
        rd_chk("unmapped_read", A_UNM, 32'h0);
        rd_chk("led_after_unm", A_LED, 32'h0000_00A5);
        rd_chk("tx_empty_read", A_TX, 32'h0);

        // fill past full with consumer stalled
        tx_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h45; b++) begin
            if (b <= 8'h44) tx_q.push_back(8'(b));
            do_write(A_TX, 32'(b));
        end
        rd_chk("status_ovf", A_ST, 32'h0000_0025);
        rd_chk("tx_peek", A_TX, 32'h0000_0041);
        rd_chk("tx_peek_again", A_TX, 32'h0000_0041);

        // drain on consecutive cycles
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            sig_chk("drain_valid", {31'b0, tx_valid}, 32'h1);
            compare_tx("drain_byte");
            @(negedge clk);
        end
        #1;
        sig_chk("drained_valid", {31'b0, tx_valid}, 32'h0);
        rd_chk("status_drained", A_ST, 32'h0000_0006);

        do_write(A_ST, 32'h0000_0004);
        rd_chk("status_ovf_clr", A_ST, 32'h0000_0002);

        // tx_ready while empty does nothing; push to empty shows next cycle
        repeat (3) @(negedge clk);
        rd_chk("status_idle_ready", A_ST, 32'h0000_0002);
        tx_q.push_back(8'h60);
        do_write(A_TX, 32'h0000_0060);
        #1;
        sig_chk("push_empty_valid", {31'b0, tx_valid}, 32'h1);
        rd_chk("status_one", A_ST, 32'h0000_0008);
        compare_tx("push_empty_byte");
        @(negedge clk);
        #1;
        sig_chk("single_popped", {31'b0, tx_valid}, 32'h0);

        // push and pop together while full
        tx_ready = 1'b0;
        for (int b = 8'h51; b <= 8'h54; b++) begin
            tx_q.push_back(8'(b));
            do_write(A_TX, 32'(b));
        end
        rd_chk("status_full", A_ST, 32'h0000_0021);
        tx_ready = 1'b1;
        tx_q.push_back(8'h55);
        #1;
        compare_tx("full_head");
        do_write(A_TX, 32'h0000_0055);
        tx_ready = 1'b0;
        rd_chk("status_pushpop", A_ST, 32'h0000_0021);
        rd_chk("tx_head_after", A_TX, 32'h0000_0052);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            sig_chk("drain2_valid", {31'b0, tx_valid}, 32'h1);
            compare_tx("drain2_byte");
            @(negedge clk);
        end
        #1;
        sig_chk("drain2_done", {31'b0, tx_valid}, 32'h0);
        sig_chk("tx_q_left", 32'(tx_q.size()), 32'h0);
        rd_chk("status_drain2", A_ST, 32'h0000_0002);

        // reset mid-stream
        tx_ready = 1'b0;
        @(negedge clk);
        for (int b = 8'h71; b <= 8'h73; b++) begin
            do_write(A_TX, 32'(b));
        end
        rd_chk("status_three", A_ST, 32'h0000_0018);
        sig_chk("led_before_rst", {24'b0, led}, 32'h0000_00A5);
        #2;
        reset = 1'b1;
        #1;
        sig_chk("rst_mid_valid", {31'b0, tx_valid}, 32'h0);
        rd_chk("rst_mid_status", A_ST, 32'h0000_0002);
        sig_chk("rst_mid_led", {24'b0, led}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        sig_chk("post_rst_valid", {31'b0, tx_valid}, 32'h0);
        rd_chk("post_rst_status", A_ST, 32'h0000_0002);
        rd_chk("ram_survives_rst", 32'h0000_003C, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
